// File: rtl/id_ex_issue_register.sv
// ID/EX issue register for the two-slot (ALU + memory) VLIW bundle.
// Registers decoded fields and register-file data, inserts bubbles, and forwards operands into EX.
module id_ex_issue_register #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p2_stall,
  input  logic              flush,
  input  logic              p1_valid,
  input  logic [4:0]        p1_alu_op,
  input  logic [2:0]        p1_alu_rd,
  input  logic [2:0]        p1_alu_rn,
  input  logic [2:0]        p1_alu_rm,
  input  logic              p1_alu_regWrite,
  input  logic              p1_alu_useImm,
  input  logic [IMM_W-1:0]  p1_alu_imm,
  input  logic [4:0]        p1_mem_op,
  input  logic [2:0]        p1_mem_rd,
  input  logic [2:0]        p1_mem_rn,
  input  logic              p1_mem_regWrite,
  input  logic              p1_mem_read,
  input  logic              p1_mem_write,
  input  logic [IMM_W-1:0]  p1_mem_off,
  input  logic [DATA_W-1:0] rf_alu_rn,
  input  logic [DATA_W-1:0] rf_alu_rm,
  input  logic [DATA_W-1:0] rf_mem_rn,
  input  logic [DATA_W-1:0] rf_mem_rd,
  input  logic [1:0]        f_alu_reg_rn_sel,
  input  logic [1:0]        f_alu_reg_rm_sel,
  input  logic [1:0]        f_mem_reg_rn_sel,
  input  logic [1:0]        f_mem_reg_rd_sel,
  input  logic [DATA_W-1:0] p3_alu_result,
  input  logic [DATA_W-1:0] p4_alu_result,
  input  logic [DATA_W-1:0] p4_mem_result,
  output logic              p2_valid,
  output logic [4:0]        p2_alu_op,
  output logic [4:0]        p2_mem_op,
  output logic [2:0]        p2_alu_rd,
  output logic [2:0]        p2_alu_rn,
  output logic [2:0]        p2_alu_rm,
  output logic [2:0]        p2_mem_rd,
  output logic [2:0]        p2_mem_rn,
  output logic              p2_alu_regWrite,
  output logic              p2_mem_regWrite,
  output logic              p2_mem_read,
  output logic              p2_mem_write,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [DATA_W-1:0] ex_mem_addr,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_valid;
  logic [4:0]        r_alu_op;
  logic [4:0]        r_mem_op;
  logic [2:0]        r_alu_rd;
  logic [2:0]        r_alu_rn;
  logic [2:0]        r_alu_rm;
  logic [2:0]        r_mem_rd;
  logic [2:0]        r_mem_rn;
  logic              r_alu_regWrite;
  logic              r_mem_regWrite;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_alu_useImm;
  logic [IMM_W-1:0]  r_alu_imm;
  logic [IMM_W-1:0]  r_mem_off;
  logic [DATA_W-1:0] r_rf_alu_rn;
  logic [DATA_W-1:0] r_rf_alu_rm;
  logic [DATA_W-1:0] r_rf_mem_rn;
  logic [DATA_W-1:0] r_rf_mem_rd;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_bubble;
  logic [DATA_W-1:0] w_alu_rn_fwd;
  logic [DATA_W-1:0] w_alu_rm_fwd;
  logic [DATA_W-1:0] w_mem_rn_fwd;
  logic [DATA_W-1:0] w_mem_rd_fwd;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_off_sext;

  // Flush and stall collapse into one bubble, so simultaneous requests count once.
  assign w_bubble = flush | p2_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid        <= 1'b0;
      r_alu_op       <= '0;
      r_mem_op       <= '0;
      r_alu_rd       <= '0;
      r_alu_rn       <= '0;
      r_alu_rm       <= '0;
      r_mem_rd       <= '0;
      r_mem_rn       <= '0;
      r_alu_regWrite <= 1'b0;
      r_mem_regWrite <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_alu_useImm   <= 1'b0;
      r_alu_imm      <= '0;
      r_mem_off      <= '0;
      r_rf_alu_rn    <= '0;
      r_rf_alu_rm    <= '0;
      r_rf_mem_rn    <= '0;
      r_rf_mem_rd    <= '0;
      r_bubble_cnt   <= '0;
    end else if (w_bubble) begin
      // Zeroed indices keep the forwarding/hazard units from matching a bubble; data is left alone.
      r_valid        <= 1'b0;
      r_alu_op       <= '0;
      r_mem_op       <= '0;
      r_alu_rd       <= '0;
      r_alu_rn       <= '0;
      r_alu_rm       <= '0;
      r_mem_rd       <= '0;
      r_mem_rn       <= '0;
      r_alu_regWrite <= 1'b0;
      r_mem_regWrite <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      if (r_bubble_cnt != {CNT_W{1'b1}}) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else begin
      r_valid        <= p1_valid;
      r_alu_op       <= p1_alu_op;
      r_mem_op       <= p1_mem_op;
      r_alu_rd       <= p1_alu_rd;
      r_alu_rn       <= p1_alu_rn;
      r_alu_rm       <= p1_alu_rm;
      r_mem_rd       <= p1_mem_rd;
      r_mem_rn       <= p1_mem_rn;
      r_alu_regWrite <= p1_valid & p1_alu_regWrite;
      r_mem_regWrite <= p1_valid & p1_mem_regWrite;
      r_mem_read     <= p1_valid & p1_mem_read;
      r_mem_write    <= p1_valid & p1_mem_write;
      r_alu_useImm   <= p1_alu_useImm;
      r_alu_imm      <= p1_alu_imm;
      r_mem_off      <= p1_mem_off;
      r_rf_alu_rn    <= rf_alu_rn;
      r_rf_alu_rm    <= rf_alu_rm;
      r_rf_mem_rn    <= rf_mem_rn;
      r_rf_mem_rd    <= rf_mem_rd;
    end
  end

  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf_val,
    input logic [DATA_W-1:0] p3_alu,
    input logic [DATA_W-1:0] p4_alu,
    input logic [DATA_W-1:0] p4_mem
  );
    logic [DATA_W-1:0] v;
    case (sel)
      2'd0:    v = rf_val;
      2'd1:    v = p3_alu;
      2'd2:    v = p4_alu;
      default: v = p4_mem;
    endcase
    return v;
  endfunction

  // Selects are live inputs: forwarding resolves in the EX cycle itself.
  assign w_alu_rn_fwd = fwd_mux(f_alu_reg_rn_sel, r_rf_alu_rn, p3_alu_result, p4_alu_result, p4_mem_result);
  assign w_alu_rm_fwd = fwd_mux(f_alu_reg_rm_sel, r_rf_alu_rm, p3_alu_result, p4_alu_result, p4_mem_result);
  assign w_mem_rn_fwd = fwd_mux(f_mem_reg_rn_sel, r_rf_mem_rn, p3_alu_result, p4_alu_result, p4_mem_result);
  assign w_mem_rd_fwd = fwd_mux(f_mem_reg_rd_sel, r_rf_mem_rd, p3_alu_result, p4_alu_result, p4_mem_result);

  assign w_imm_sext = {{(DATA_W-IMM_W){r_alu_imm[IMM_W-1]}}, r_alu_imm};
  assign w_off_sext = {{(DATA_W-IMM_W){r_mem_off[IMM_W-1]}}, r_mem_off};

  assign ex_alu_a      = w_alu_rn_fwd;
  assign ex_alu_b      = r_alu_useImm ? w_imm_sext : w_alu_rm_fwd;
  assign ex_mem_addr   = w_mem_rn_fwd + w_off_sext;
  assign ex_store_data = w_mem_rd_fwd;

  assign p2_valid        = r_valid;
  assign p2_alu_op       = r_alu_op;
  assign p2_mem_op       = r_mem_op;
  assign p2_alu_rd       = r_alu_rd;
  assign p2_alu_rn       = r_alu_rn;
  assign p2_alu_rm       = r_alu_rm;
  assign p2_mem_rd       = r_mem_rd;
  assign p2_mem_rn       = r_mem_rn;
  assign p2_alu_regWrite = r_alu_regWrite;
  assign p2_mem_regWrite = r_mem_regWrite;
  assign p2_mem_read     = r_mem_read;
  assign p2_mem_write    = r_mem_write;
  assign bubble_cnt      = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_issue_register.sv
// Directed bench for id_ex_issue_register: vector table plus memory, saturation and async-reset sequences.
module tb_id_ex_issue_register;
  localparam int DATA_W = 16;
  localparam int IMM_W  = 6;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic p2_stall, flush, p1_valid;
  logic [4:0] p1_alu_op, p1_mem_op;
  logic [2:0] p1_alu_rd, p1_alu_rn, p1_alu_rm, p1_mem_rd, p1_mem_rn;
  logic p1_alu_regWrite, p1_alu_useImm, p1_mem_regWrite, p1_mem_read, p1_mem_write;
  logic [IMM_W-1:0] p1_alu_imm, p1_mem_off;
  logic [DATA_W-1:0] rf_alu_rn, rf_alu_rm, rf_mem_rn, rf_mem_rd;
  logic [1:0] f_alu_reg_rn_sel, f_alu_reg_rm_sel, f_mem_reg_rn_sel, f_mem_reg_rd_sel;
  logic [DATA_W-1:0] p3_alu_result, p4_alu_result, p4_mem_result;
  logic p2_valid;
  logic [4:0] p2_alu_op, p2_mem_op;
  logic [2:0] p2_alu_rd, p2_alu_rn, p2_alu_rm, p2_mem_rd, p2_mem_rn;
  logic p2_alu_regWrite, p2_mem_regWrite, p2_mem_read, p2_mem_write;
  logic [DATA_W-1:0] ex_alu_a, ex_alu_b, ex_mem_addr, ex_store_data;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_issue_register #(.DATA_W(DATA_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .p2_stall(p2_stall), .flush(flush), .p1_valid(p1_valid),
    .p1_alu_op(p1_alu_op), .p1_alu_rd(p1_alu_rd), .p1_alu_rn(p1_alu_rn), .p1_alu_rm(p1_alu_rm),
    .p1_alu_regWrite(p1_alu_regWrite), .p1_alu_useImm(p1_alu_useImm), .p1_alu_imm(p1_alu_imm),
    .p1_mem_op(p1_mem_op), .p1_mem_rd(p1_mem_rd), .p1_mem_rn(p1_mem_rn),
    .p1_mem_regWrite(p1_mem_regWrite), .p1_mem_read(p1_mem_read), .p1_mem_write(p1_mem_write),
    .p1_mem_off(p1_mem_off), .rf_alu_rn(rf_alu_rn), .rf_alu_rm(rf_alu_rm), .rf_mem_rn(rf_mem_rn),
    .rf_mem_rd(rf_mem_rd), .f_alu_reg_rn_sel(f_alu_reg_rn_sel), .f_alu_reg_rm_sel(f_alu_reg_rm_sel),
    .f_mem_reg_rn_sel(f_mem_reg_rn_sel), .f_mem_reg_rd_sel(f_mem_reg_rd_sel),
    .p3_alu_result(p3_alu_result), .p4_alu_result(p4_alu_result), .p4_mem_result(p4_mem_result),
    .p2_valid(p2_valid), .p2_alu_op(p2_alu_op), .p2_mem_op(p2_mem_op), .p2_alu_rd(p2_alu_rd),
    .p2_alu_rn(p2_alu_rn), .p2_alu_rm(p2_alu_rm), .p2_mem_rd(p2_mem_rd), .p2_mem_rn(p2_mem_rn),
    .p2_alu_regWrite(p2_alu_regWrite), .p2_mem_regWrite(p2_mem_regWrite),
    .p2_mem_read(p2_mem_read), .p2_mem_write(p2_mem_write), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        stall;
    logic        flush;
    logic        valid;
    logic [4:0]  op;
    logic [2:0]  rd;
    logic        rw;
    logic        use_imm;
    logic [5:0]  imm;
    logic [15:0] rf_rn;
    logic [15:0] rf_rm;
    logic [1:0]  sel_rn;
    logic [1:0]  sel_rm;
    logic        e_valid;
    logic [4:0]  e_op;
    logic [2:0]  e_rd;
    logic        e_rw;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    p2_stall = 1'b1; flush = 1'b0; p1_valid = 1'b1;
    p1_alu_op = 5'h03; p1_alu_rd = 3'd3; p1_alu_rn = 3'd1; p1_alu_rm = 3'd2;
    p1_alu_regWrite = 1'b1; p1_alu_useImm = 1'b0; p1_alu_imm = 6'h00;
    p1_mem_op = 5'h11; p1_mem_rd = 3'd6; p1_mem_rn = 3'd7;
    p1_mem_regWrite = 1'b1; p1_mem_read = 1'b1; p1_mem_write = 1'b0; p1_mem_off = 6'h05;
    rf_alu_rn = 16'h0001; rf_alu_rm = 16'h0002; rf_mem_rn = 16'h0100; rf_mem_rd = 16'h0200;
    f_alu_reg_rn_sel = 2'd0; f_alu_reg_rm_sel = 2'd0; f_mem_reg_rn_sel = 2'd0; f_mem_reg_rd_sel = 2'd0;
    p3_alu_result = 16'h00AA; p4_alu_result = 16'h00BB; p4_mem_result = 16'h00CC;

    //              stl  fl   vld  op     rd    rw   ui   imm        rf_rn     rf_rm     srn   srm    ev   eop    erd   erw  ea        eb        ecnt
    tbl[0] = '{1'b0,1'b0,1'b1,5'h03,3'd3,1'b1,1'b0,6'b000000,16'h0001,16'h0002,2'd0,2'd0, 1'b1,5'h03,3'd3,1'b1,16'h0001,16'h0002,4'd0};
    tbl[1] = '{1'b0,1'b0,1'b1,5'h03,3'd3,1'b1,1'b0,6'b000000,16'h0001,16'h0002,2'd1,2'd2, 1'b1,5'h03,3'd3,1'b1,16'h00AA,16'h00BB,4'd0};
    tbl[2] = '{1'b0,1'b0,1'b1,5'h03,3'd3,1'b1,1'b0,6'b000000,16'h0001,16'h0002,2'd2,2'd3, 1'b1,5'h03,3'd3,1'b1,16'h00BB,16'h00CC,4'd0};
    tbl[3] = '{1'b0,1'b0,1'b1,5'h03,3'd3,1'b1,1'b0,6'b000000,16'h0001,16'h0002,2'd3,2'd0, 1'b1,5'h03,3'd3,1'b1,16'h00CC,16'h0002,4'd0};
    tbl[4] = '{1'b1,1'b0,1'b1,5'h07,3'd5,1'b1,1'b0,6'b000000,16'h1234,16'h5555,2'd0,2'd0, 1'b0,5'h00,3'd0,1'b0,16'h0001,16'h0002,4'd1};
    tbl[5] = '{1'b1,1'b0,1'b1,5'h07,3'd5,1'b1,1'b0,6'b000000,16'h1234,16'h5555,2'd0,2'd0, 1'b0,5'h00,3'd0,1'b0,16'h0001,16'h0002,4'd2};
    tbl[6] = '{1'b1,1'b1,1'b1,5'h07,3'd5,1'b1,1'b0,6'b000000,16'h1234,16'h5555,2'd0,2'd0, 1'b0,5'h00,3'd0,1'b0,16'h0001,16'h0002,4'd3};
    tbl[7] = '{1'b0,1'b0,1'b0,5'h07,3'd5,1'b1,1'b0,6'b000000,16'h1234,16'h5555,2'd0,2'd0, 1'b0,5'h07,3'd5,1'b0,16'h1234,16'h5555,4'd3};
    tbl[8] = '{1'b0,1'b0,1'b1,5'h07,3'd5,1'b1,1'b1,6'b111110,16'h1234,16'h5555,2'd0,2'd1, 1'b1,5'h07,3'd5,1'b1,16'h1234,16'hFFFE,4'd3};
    tbl[9] = '{1'b0,1'b1,1'b1,5'h09,3'd4,1'b1,1'b0,6'b000001,16'h7777,16'h8888,2'd0,2'd1, 1'b0,5'h00,3'd0,1'b0,16'h1234,16'hFFFE,4'd4};

    // Reset held with p1 activity and a stall request: nothing may move.
    repeat (3) step();
    chk("rst_valid", p2_valid, 0);
    chk("rst_alu_op", p2_alu_op, 0);
    chk("rst_alu_rd", p2_alu_rd, 0);
    chk("rst_alu_rw", p2_alu_regWrite, 0);
    chk("rst_mem_read", p2_mem_read, 0);
    chk("rst_mem_rn", p2_mem_rn, 0);
    chk("rst_alu_a", ex_alu_a, 0);
    chk("rst_mem_addr", ex_mem_addr, 0);
    chk("rst_cnt", bubble_cnt, 0);
    reset_n = 1'b1;
    p1_mem_read = 1'b0; p1_mem_regWrite = 1'b0;

    for (int i = 0; i < 10; i++) begin
      p2_stall = tbl[i].stall; flush = tbl[i].flush; p1_valid = tbl[i].valid;
      p1_alu_op = tbl[i].op; p1_alu_rd = tbl[i].rd; p1_alu_regWrite = tbl[i].rw;
      p1_alu_useImm = tbl[i].use_imm; p1_alu_imm = tbl[i].imm;
      rf_alu_rn = tbl[i].rf_rn; rf_alu_rm = tbl[i].rf_rm;
      f_alu_reg_rn_sel = tbl[i].sel_rn; f_alu_reg_rm_sel = tbl[i].sel_rm;
      step();
      chk($sformatf("v%0d_valid", i), p2_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_op", i), p2_alu_op, tbl[i].e_op);
      chk($sformatf("v%0d_rd", i), p2_alu_rd, tbl[i].e_rd);
      chk($sformatf("v%0d_rw", i), p2_alu_regWrite, tbl[i].e_rw);
      chk($sformatf("v%0d_alu_a", i), ex_alu_a, tbl[i].e_a);
      chk($sformatf("v%0d_alu_b", i), ex_alu_b, tbl[i].e_b);
      chk($sformatf("v%0d_cnt", i), bubble_cnt, tbl[i].e_cnt);
      $display("vec %0d: valid=%0b op=%0h rd=%0d a=%h b=%h cnt=%0d", i, p2_valid, p2_alu_op, p2_alu_rd, ex_alu_a, ex_alu_b, bubble_cnt);
    end

    // Memory slot: forwarded base plus negative offset wraps, store data forwarding sweep.
    p2_stall = 1'b0; flush = 1'b0; p1_valid = 1'b1;
    p1_mem_op = 5'h12; p1_mem_rd = 3'd2; p1_mem_rn = 3'd4; p1_mem_off = 6'h3F;
    p1_mem_read = 1'b1; p1_mem_regWrite = 1'b1; p1_mem_write = 1'b0;
    rf_mem_rn = 16'h0000; rf_mem_rd = 16'h0042;
    p3_alu_result = 16'h0010; f_mem_reg_rn_sel = 2'd1; f_mem_reg_rd_sel = 2'd0;
    step();
    chk("mem_addr", ex_mem_addr, 16'h000F);
    chk("mem_read", p2_mem_read, 1);
    chk("mem_rw", p2_mem_regWrite, 1);
    chk("mem_rn", p2_mem_rn, 4);
    chk("mem_op", p2_mem_op, 5'h12);
    chk("store_sel0", ex_store_data, 16'h0042);
    $display("mem: addr=%h read=%0b rn=%0d store=%h", ex_mem_addr, p2_mem_read, p2_mem_rn, ex_store_data);
    f_mem_reg_rd_sel = 2'd1; #1 chk("store_sel1", ex_store_data, 16'h0010);
    f_mem_reg_rd_sel = 2'd2; #1 chk("store_sel2", ex_store_data, 16'h00BB);
    f_mem_reg_rd_sel = 2'd3; #1 chk("store_sel3", ex_store_data, 16'h00CC);
    f_mem_reg_rn_sel = 2'd0; #1 chk("mem_addr_rf", ex_mem_addr, 16'hFFFF);
    $display("store sweep: last store=%h addr=%h", ex_store_data, ex_mem_addr);

    // Invalid bundle: controls forced low, indices still captured.
    p1_valid = 1'b0; p1_mem_write = 1'b1;
    step();
    chk("inv_mem_write", p2_mem_write, 0);
    chk("inv_mem_read", p2_mem_read, 0);
    chk("inv_mem_rn", p2_mem_rn, 4);
    $display("invalid: write=%0b read=%0b rn=%0d", p2_mem_write, p2_mem_read, p2_mem_rn);

    // Saturation: count is 4, eleven more stalls reach 15, further stalls hold it.
    p2_stall = 1'b1;
    repeat (11) step();
    chk("sat_reach", bubble_cnt, 4'hF);
    repeat (9) step();
    chk("sat_hold", bubble_cnt, 4'hF);
    $display("saturate: cnt=%0h", bubble_cnt);

    // Reset mid-cycle, away from any edge, must clear immediately.
    #2 reset_n = 1'b0;
    #1;
    chk("async_cnt", bubble_cnt, 0);
    chk("async_mem_rn", p2_mem_rn, 0);
    chk("async_alu_a", ex_alu_a, 0);
    $display("async reset: cnt=%0d alu_a=%h", bubble_cnt, ex_alu_a);
    reset_n = 1'b1;
    p2_stall = 1'b0; p1_valid = 1'b1; p1_alu_op = 5'h03;
    step();
    chk("post_rst_op", p2_alu_op, 5'h03);
    chk("post_rst_valid", p2_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/id_ex_issue_register.md
Name: id_ex_issue_register

Overview:
- ID/EX pipeline register for the two-slot VLIW bundle: ALU slot and memory slot.
- Sits between decode/register-read (p1) and execute (p2).
- Captures decoded fields and register-file read data each cycle.
- Inserts a bubble when hazard detection stalls or when the branch logic flushes.
- Applies the forwarding-unit selects to produce final EX operands, store data and an immediate-muxed ALU B operand.

Parameters:
- DATA_W, 16, datapath and register width.
- IMM_W, 6, immediate/offset field width; sign-extended to DATA_W.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- p2_stall  in  1  hazard-detection bubble request
- flush  in  1  branch flush of the bundle being issued
- p1_valid  in  1  decode holds a real bundle
- p1_alu_op  in  5  ALU opcode
- p1_alu_rd/p1_alu_rn/p1_alu_rm  in  3 each  ALU register indices
- p1_alu_regWrite  in  1  ALU slot writes rd
- p1_alu_useImm  in  1  ALU B operand is the immediate
- p1_alu_imm  in  IMM_W  ALU immediate
- p1_mem_op  in  5  memory opcode
- p1_mem_rd/p1_mem_rn  in  3 each  memory register indices
- p1_mem_regWrite/p1_mem_read/p1_mem_write  in  1 each  memory-slot controls
- p1_mem_off  in  IMM_W  address offset
- rf_alu_rn/rf_alu_rm/rf_mem_rn/rf_mem_rd  in  DATA_W each  register-file read data
- f_alu_reg_rn_sel/f_alu_reg_rm_sel/f_mem_reg_rn_sel/f_mem_reg_rd_sel  in  2 each  forwarding selects
- p3_alu_result/p4_alu_result/p4_mem_result  in  DATA_W each  forwarding sources
- p2_valid  out  1  EX bundle is real
- p2_alu_op/p2_mem_op  out  5 each  registered opcodes
- p2_alu_rd/p2_alu_rn/p2_alu_rm/p2_mem_rd/p2_mem_rn  out  3 each  registered indices; drive the forwarding and hazard units
- p2_alu_regWrite/p2_mem_regWrite/p2_mem_read/p2_mem_write  out  1 each  registered controls
- ex_alu_a/ex_alu_b  out  DATA_W each  final ALU operands
- ex_mem_addr  out  DATA_W  forwarded rn plus sign-extended offset, modulo 2^DATA_W
- ex_store_data  out  DATA_W  forwarded rd value for stores
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, reset_n=0): all registered outputs 0, including p2_valid, all indices, all controls, all data fields and bubble_cnt.
- Reset is immediate mid-cycle; the first capture occurs on the first clk rising edge after reset_n rises.
- Each rising edge, priority order is: flush, then p2_stall, then normal load.
- Bubble (flush=1 or p2_stall=1):
  - p2_valid, all regWrite/read/write controls, both opcodes and all five indices are set to 0.
  - Registered data fields hold their old values.
  - Zero indices guarantee no downstream forwarding or hazard match.
  - bubble_cnt increments by 1, saturating at 2^CNT_W-1; no wrap.
- Simultaneous flush and p2_stall: a single bubble; bubble_cnt +1, not +2.
- Normal load: all p1_* fields and rf_* data are captured.
  - p2_valid=p1_valid.
  - If p1_valid=0, all controls are forced to 0 and indices are captured as-is.
- Registered latency is 1 cycle from p1 to p2. Forwarding is combinational within p2.
- Forwarding mux, per operand (sel 0 = registered rf value, 1 = p3_alu_result, 2 = p4_alu_result, 3 = p4_mem_result):
  - ex_alu_a uses f_alu_reg_rn_sel.
  - ALU rm value uses f_alu_reg_rm_sel.
  - Memory base uses f_mem_reg_rn_sel.
  - ex_store_data uses f_mem_reg_rd_sel.
- ex_alu_b = sign-extended registered imm when registered useImm=1, otherwise the forwarded rm value. The immediate is never overridden by forwarding.
- ex_mem_addr = forwarded base + sign-extended registered offset; carry-out is discarded.
- Selects are sampled by the combinational path in the same cycle. The block never stores selects.

Test Plan:
- Reset: hold reset_n=0 with p1 activity -> every output 0, bubble_cnt=0. Release reset_n -> next edge captures p1_alu_op=5'h03, p2_alu_op=5'h03, p2_valid=1.
- Stall: load bundle alu_rd=3, regWrite=1, then p2_stall=1 for 2 cycles -> p2_alu_rd=0, p2_alu_regWrite=0, p2_valid=0 for both cycles; bubble_cnt=2.
- Flush plus stall: flush=1 and p2_stall=1 together -> one bubble, bubble_cnt increments by exactly 1.
- Forwarding: rf_alu_rn=16'h0001, p3_alu_result=16'h00AA, p4_alu_result=16'h00BB, p4_mem_result=16'h00CC; sweep f_alu_reg_rn_sel 0..3 -> ex_alu_a=0001/00AA/00BB/00CC.
- Immediate: useImm=1, imm=6'b111110, f_alu_reg_rm_sel=1 -> ex_alu_b=16'hFFFE. Base forwarded 16'h0010 with off=6'h3F -> ex_mem_addr=16'h000F.
- Saturation: CNT_W=4, 20 consecutive stalls -> bubble_cnt stays at 4'hF. Assert reset_n=0 mid-stall -> bubble_cnt=0 asynchronously.
